hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and control unit for the 5-stage J pipeline. It drives the write-enable (`nwrite`, active-high stall) and `flush` inputs of the PC register, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, taken branches resolved in EX, jumps resolved in ID, and multi-cycle MDU (mult/div) occupancy of EX. It also keeps a saturating count of stalled cycles for performance monitoring.

## Interface
- `MDU_LATENCY`, default 4: total cycles a mult/div instruction occupies EX; legal range 1..16.
- `clock` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low.
- `id_rs` input 5: rs field of the instruction in ID.
- `id_rt` input 5: rt field of the instruction in ID.
- `id_uses_rs` input 1: ID instruction reads rs.
- `id_uses_rt` input 1: ID instruction reads rt.
- `id_jump` input 1: ID instruction is J/JAL; target is taken in ID.
- `ex_mem_read` input 1: EX instruction is a load.
- `ex_rd` input 5: destination register of the EX instruction.
- `ex_branch_taken` input 1: branch in EX resolved taken.
- `ex_mdu_start` input 1: EX instruction is mult/div; mutually exclusive with `ex_mem_read`.
- `pc_nwrite` output 1: hold PC.
- `if2id_nwrite` output 1: hold IF/ID.
- `if2id_flush` output 1: clear IF/ID to NOP.
- `id2ex_nwrite` output 1: hold ID/EX.
- `id2ex_flush` output 1: clear ID/EX to NOP.
- `ex2mem_flush` output 1: insert a bubble into EX/MEM.
- `mdu_busy` output 1: FSM is in BUSY.
- `stall_cycles` output 16: saturating count of cycles with `pc_nwrite`=1.

## Operation
- **FSM states:** RUN, BUSY. There is also a 4-bit down-counter `cnt`.
- **Control outputs:** combinational from state, `cnt` and inputs. While `reset`=0, every control output is 0.
- **Priority in RUN (highest first):**
  1. **`ex_mdu_start`, MDU_LATENCY>1:**
     - Asserts `pc_nwrite`, `if2id_nwrite`, `id2ex_nwrite`, `ex2mem_flush`.
     - Next state BUSY, `cnt` ← MDU_LATENCY−1.
     - With MDU_LATENCY=1, `ex_mdu_start` is ignored.
  2. **`ex_branch_taken`:**
     - Asserts `if2id_flush`, `id2ex_flush`.
     - No stall; the PC loads the target.
     - Overrides load-use and `id_jump`, because the ID instruction is squashed.
  3. **Load-use:** `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs` && `id_rs`==`ex_rd`) || (`id_uses_rt` && `id_rt`==`ex_rd`)).
     - Asserts `pc_nwrite`, `if2id_nwrite`, `id2ex_flush`.
     - This is a one-cycle bubble.
     - A simultaneous `id_jump` is deferred: the jump stays in ID and is honoured the next cycle.
  4. **`id_jump`:** asserts `if2id_flush` only, killing the slot fetched after the jump.
  5. **Otherwise:** all control outputs 0.
- **BUSY:**
  - `mdu_busy`=1.
  - If `cnt`>1: assert `pc_nwrite`, `if2id_nwrite`, `id2ex_nwrite`, `ex2mem_flush`; `cnt` ← `cnt`−1.
  - If `cnt`==1: all control outputs 0; next state RUN.
  - `ex_branch_taken`, `ex_mem_read` and `ex_mdu_start` are ignored, because EX holds the MDU instruction.
- **`stall_cycles`:** +1 at each edge where `pc_nwrite`=1; holds at 0xFFFF.
- **Reset:** reset=0 at an edge sets state RUN, `cnt` 0, `stall_cycles` 0. Reset mid-BUSY aborts the stall immediately.

## Timing
- **Reset values after a reset edge:** all control outputs 0, `mdu_busy` 0, `stall_cycles` 0.
- **Hazard outputs:** zero-latency (combinational) with respect to ID/EX inputs. The consuming registers act at the same edge.
- **Load-use:** exactly 1 stall cycle. At the next edge the load leaves EX and a NOP enters EX, so the hazard clears without FSM state.
- **MDU:**
  - The instruction occupies EX for MDU_LATENCY cycles.
  - Stall is asserted for MDU_LATENCY−1 of those cycles: the start cycle plus MDU_LATENCY−2 BUSY cycles.
  - BUSY lasts MDU_LATENCY−1 cycles. The last BUSY cycle releases the stall so the next edge advances the pipeline.
  - MDU_LATENCY=2 gives a single stall cycle and one BUSY cycle with outputs 0.
- **Flushes:** single-cycle pulses; never asserted in the same cycle as the matching `nwrite` for the same register.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_uses_rt`=1, `id_rt`=5 → `pc_nwrite`=`if2id_nwrite`=`id2ex_flush`=1 for exactly 1 cycle; `stall_cycles` 0→1. Repeat with `ex_rd`=0 → no stall.
- **Branch vs. load-use:** `ex_branch_taken`=1 with a load-use hit on the same cycle → `if2id_flush`=`id2ex_flush`=1, `pc_nwrite`=0, `stall_cycles` unchanged.
- **Jump:** `id_jump`=1 alone → `if2id_flush`=1 for 1 cycle. With a simultaneous load-use → stall first cycle (`if2id_flush`=0), `if2id_flush`=1 the following cycle.
- **MDU, MDU_LATENCY=4:** `ex_mdu_start` pulse → stall outputs high for 3 consecutive cycles; `mdu_busy` high for 3 cycles (last with outputs 0); `stall_cycles`=3. Repeat with MDU_LATENCY=1 → no stall, `mdu_busy` never 1.
- **Reset mid-operation:** reset=0 during the 2nd BUSY cycle → control outputs 0 immediately; after the edge, state RUN and `stall_cycles`=0.
- **Saturation:** force 65 540 load-use stall cycles → `stall_cycles` reaches and holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline-register control outputs of hazard_ctrl
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_jump;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        ex_mdu_start;
    logic        pc_nwrite;
    logic        if2id_nwrite;
    logic        if2id_flush;
    logic        id2ex_nwrite;
    logic        id2ex_flush;
    logic        ex2mem_flush;
    logic        mdu_busy;
    logic [15:0] stall_cycles;
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
               ex_mem_read, ex_rd, ex_branch_taken, ex_mdu_start,
        input  pc_nwrite, if2id_nwrite, if2id_flush, id2ex_nwrite,
               id2ex_flush, ex2mem_flush, mdu_busy, stall_cycles
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
               ex_mem_read, ex_rd, ex_branch_taken, ex_mdu_start,
        output pc_nwrite, if2id_nwrite, if2id_flush, id2ex_nwrite,
               id2ex_flush, ex2mem_flush, mdu_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/jump/MDU hazard control for the 5-stage pipeline with stall counter
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4
) (
    input logic          clock,
    input logic          reset,
    hazard_ctrl_if.slave h
);
    typedef enum logic {RUN, BUSY} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [15:0] stall_cnt;
    logic        load_use, mdu_go;
    always_comb begin
        load_use = h.ex_mem_read && h.ex_rd != 5'd0 &&
                   ((h.id_uses_rs && h.id_rs == h.ex_rd) || (h.id_uses_rt && h.id_rt == h.ex_rd));
        mdu_go = MDU_LATENCY > 1 && h.ex_mdu_start;
        state_nx = state;
        cnt_nx = cnt;
        h.pc_nwrite = 1'b0;
        h.if2id_nwrite = 1'b0;
        h.if2id_flush = 1'b0;
        h.id2ex_nwrite = 1'b0;
        h.id2ex_flush = 1'b0;
        h.ex2mem_flush = 1'b0;
        if (reset) begin
            if (state == BUSY) begin
                // EX holds the MDU op: EX-side hazards are irrelevant until it drains
                if (cnt > 4'd1) begin
                    h.pc_nwrite = 1'b1;
                    h.if2id_nwrite = 1'b1;
                    h.id2ex_nwrite = 1'b1;
                    h.ex2mem_flush = 1'b1;
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = RUN;
                end
            end else if (mdu_go) begin
                h.pc_nwrite = 1'b1;
                h.if2id_nwrite = 1'b1;
                h.id2ex_nwrite = 1'b1;
                h.ex2mem_flush = 1'b1;
                state_nx = BUSY;
                cnt_nx = 4'(MDU_LATENCY - 1);
            end else if (h.ex_branch_taken) begin
                h.if2id_flush = 1'b1;
                h.id2ex_flush = 1'b1;
            end else if (load_use) begin
                h.pc_nwrite = 1'b1;
                h.if2id_nwrite = 1'b1;
                h.id2ex_flush = 1'b1;
            end else if (h.id_jump) begin
                h.if2id_flush = 1'b1;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
            cnt <= 4'd0;
            stall_cnt <= 16'd0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (h.pc_nwrite && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
    assign h.mdu_busy = state == BUSY;
    assign h.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl at MDU_LATENCY 4 and 1 driven in lockstep
module tb_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;
    hazard_ctrl_if h4 ();
    hazard_ctrl_if h1 ();
    hazard_ctrl #(.MDU_LATENCY(4)) u4 (.clock(clock), .reset(reset), .h(h4.slave));
    hazard_ctrl #(.MDU_LATENCY(1)) u1 (.clock(clock), .reset(reset), .h(h1.slave));
    assign h1.id_rs = h4.id_rs;
    assign h1.id_rt = h4.id_rt;
    assign h1.id_uses_rs = h4.id_uses_rs;
    assign h1.id_uses_rt = h4.id_uses_rt;
    assign h1.id_jump = h4.id_jump;
    assign h1.ex_mem_read = h4.ex_mem_read;
    assign h1.ex_rd = h4.ex_rd;
    assign h1.ex_branch_taken = h4.ex_branch_taken;
    assign h1.ex_mdu_start = h4.ex_mdu_start;

    // ctl = {pc_nw, if2id_nw, if2id_fl, id2ex_nw, id2ex_fl, ex2mem_fl, mdu_busy}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] BR   = 7'b0010100;
    localparam logic [6:0] JMP  = 7'b0010000;
    localparam logic [6:0] MDUS = 7'b1101010;
    localparam logic [6:0] BSTL = 7'b1101011;
    localparam logic [6:0] BREL = 7'b0000001;

    typedef struct {
        string       name;
        logic [6:0]  c4;
        logic [15:0] s4;
        logic [6:0]  c1;
        logic [15:0] s1;
    } exp_t;
    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp({e.name, "/ctl4"}, 16'({h4.pc_nwrite, h4.if2id_nwrite, h4.if2id_flush, h4.id2ex_nwrite,
                                        h4.id2ex_flush, h4.ex2mem_flush, h4.mdu_busy}), 16'(e.c4));
            cmp({e.name, "/stall4"}, h4.stall_cycles, e.s4);
            cmp({e.name, "/ctl1"}, 16'({h1.pc_nwrite, h1.if2id_nwrite, h1.if2id_flush, h1.id2ex_nwrite,
                                        h1.id2ex_flush, h1.ex2mem_flush, h1.mdu_busy}), 16'(e.c1));
            cmp({e.name, "/stall1"}, h1.stall_cycles, e.s1);
        end
    end

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                          input logic jmp, input logic mr, input logic [4:0] rd, input logic br, input logic mdu);
        h4.id_rs = rs;
        h4.id_rt = rt;
        h4.id_uses_rs = urs;
        h4.id_uses_rt = urt;
        h4.id_jump = jmp;
        h4.ex_mem_read = mr;
        h4.ex_rd = rd;
        h4.ex_branch_taken = br;
        h4.ex_mdu_start = mdu;
    endtask

    task automatic expect_cycle(input string name, input logic [6:0] c4, input logic [15:0] s4,
                                input logic [6:0] c1, input logic [15:0] s1);
        q.push_back('{name, c4, s4, c1, s1});
        @(posedge clock);
        #1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        expect_cycle("reset", NONE, 0, NONE, 0);
        reset = 1'b1;
        expect_cycle("idle", NONE, 0, NONE, 0);
        set_in(0, 5, 0, 1, 0, 1, 5, 0, 0);
        expect_cycle("lu_rt", LU, 0, LU, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cycle("lu_clear", NONE, 1, NONE, 1);
        set_in(0, 0, 0, 1, 0, 1, 0, 0, 0);
        expect_cycle("lu_r0", NONE, 1, NONE, 1);
        set_in(7, 0, 1, 0, 0, 1, 7, 0, 0);
        expect_cycle("lu_rs", LU, 1, LU, 1);
        set_in(7, 0, 0, 0, 0, 1, 7, 0, 0);
        expect_cycle("lu_unused", NONE, 2, NONE, 2);
        set_in(0, 5, 0, 1, 0, 1, 5, 1, 0);
        expect_cycle("br_vs_lu", BR, 2, BR, 2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cycle("br_after", NONE, 2, NONE, 2);
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        expect_cycle("jump", JMP, 2, JMP, 2);
        set_in(0, 5, 0, 1, 1, 1, 5, 0, 0);
        expect_cycle("jump_lu", LU, 2, LU, 2);
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        expect_cycle("jump_defer", JMP, 3, JMP, 3);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_cycle("mdu_start", MDUS, 3, NONE, 3);
        set_in(0, 5, 0, 1, 0, 1, 5, 1, 0);
        expect_cycle("mdu_busy1", BSTL, 4, BR, 3);
        expect_cycle("mdu_busy2", BSTL, 5, BR, 3);
        expect_cycle("mdu_busy3", BREL, 6, BR, 3);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cycle("mdu_done", NONE, 6, NONE, 3);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_cycle("mdu_start2", MDUS, 6, NONE, 3);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cycle("mdu2_busy1", BSTL, 7, NONE, 3);
        reset = 1'b0;
        expect_cycle("rst_mid_busy", BREL, 8, NONE, 3);
        reset = 1'b1;
        expect_cycle("rst_after", NONE, 0, NONE, 0);
        expect_cycle("rst_run", NONE, 0, NONE, 0);
        // saturation: hold a load-use hit for 65540 counted edges
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        set_in(0, 5, 0, 1, 0, 1, 5, 0, 0);
        for (int i = 0; i < 65534; i++) begin
            @(posedge clock);
            #1;
        end
        expect_cycle("sat_fffe", LU, 16'hFFFE, LU, 16'hFFFE);
        expect_cycle("sat_ffff", LU, 16'hFFFF, LU, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
        end
        expect_cycle("sat_hold", LU, 16'hFFFF, LU, 16'hFFFF);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
